// File: rtl/ctl_link_rx.sv
`default_nettype none
// ============================================================================
// Module   : ctl_link_rx
// Purpose  : Receiving end of the inter-board player link. Synchronises and
//            deserialises a UART-style frame (start, 8 data LSB first, even
//            parity, stop), holds the last good pause/score fields and
//            reports link health through a frame timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ctl_link_rx #(
    parameter int CLKS_PER_BIT   = 650,
    parameter int TIMEOUT_CYCLES = 6_500_000,
    parameter int PAUSE_ON_LOSS  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_raw,
    output logic       player2_pause,
    output logic [6:0] player2_score,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       link_up
);

    localparam int                 c_CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_HALF    = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam int                 c_TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0]  c_TO_MAX  = c_TO_W'(TIMEOUT_CYCLES);
    localparam logic [c_TO_W-1:0]  c_TO_ONE  = c_TO_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // Synchroniser and edge-detect history; all idle at line-high level
    logic r_rx_m;
    logic r_rx_s;
    logic r_rx_prev;

    state_t             r_state,  w_state_nx;
    logic [c_CNT_W-1:0] r_cnt,    w_cnt_nx;
    logic [2:0]         r_idx,    w_idx_nx;
    logic [7:0]         r_shift,  w_shift_nx;
    logic               r_par,    w_par_nx;
    logic               w_good;
    logic               w_bad;
    logic               w_expire;

    logic               r_pause;
    logic [6:0]         r_score;
    logic               r_frame_valid;
    logic               r_frame_err;
    logic [c_TO_W-1:0]  r_to_cnt;
    logic               r_link_up;

    // Two-flop synchroniser plus previous sample for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_m    <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_m    <= rx_raw;
            r_rx_s    <= r_rx_m;
            r_rx_prev <= r_rx_s;
        end
    end

    // Receiver state register and bit-timing datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
            r_par   <= w_par_nx;
        end
    end

    assign w_expire = (r_cnt == '0);

    // Next-state logic: count down to each mid-bit sample point, then act
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_par_nx   = r_par;
        w_good     = 1'b0;
        w_bad      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (r_rx_prev && !r_rx_s) begin
                    w_cnt_nx   = c_HALF;
                    w_state_nx = S_START;
                end
            end

            S_START: begin
                if (w_expire) begin
                    if (r_rx_s) begin
                        // Line went back high before mid-start: a glitch
                        w_state_nx = S_IDLE;
                    end else begin
                        w_cnt_nx   = c_FULL;
                        w_idx_nx   = 3'd0;
                        w_state_nx = S_DATA;
                    end
                end else begin
                    w_cnt_nx = r_cnt - c_CNT_ONE;
                end
            end

            S_DATA: begin
                if (w_expire) begin
                    w_shift_nx = {r_rx_s, r_shift[7:1]};
                    w_cnt_nx   = c_FULL;
                    if (r_idx == 3'd7) begin
                        w_state_nx = S_PARITY;
                    end else begin
                        w_idx_nx = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt - c_CNT_ONE;
                end
            end

            S_PARITY: begin
                if (w_expire) begin
                    w_par_nx   = r_rx_s;
                    w_cnt_nx   = c_FULL;
                    w_state_nx = S_STOP;
                end else begin
                    w_cnt_nx = r_cnt - c_CNT_ONE;
                end
            end

            S_STOP: begin
                if (w_expire) begin
                    if (!r_rx_s) begin
                        // Framing error; line may be held low, so wait it out
                        w_bad      = 1'b1;
                        w_state_nx = S_BREAK;
                    end else if (r_par != (^r_shift)) begin
                        w_bad      = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_good     = 1'b1;
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt - c_CNT_ONE;
                end
            end

            S_BREAK: begin
                if (r_rx_s) begin
                    w_state_nx = S_IDLE;
                end
            end

            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Capture decoded fields and issue the result pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pause       <= 1'b0;
            r_score       <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_valid <= w_good;
            r_frame_err   <= w_bad;
            if (w_good) begin
                r_pause <= r_shift[0];
                r_score <= r_shift[7:1];
            end
        end
    end

    // Link watchdog: a good frame restarts it and takes priority over expiry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt  <= '0;
            r_link_up <= 1'b0;
        end else if (r_frame_valid) begin
            r_to_cnt  <= '0;
            r_link_up <= 1'b1;
        end else if (r_to_cnt == c_TO_MAX) begin
            r_link_up <= 1'b0;
        end else begin
            r_to_cnt <= r_to_cnt + c_TO_ONE;
        end
    end

    generate
        if (PAUSE_ON_LOSS != 0) begin : g_pause_on_loss
            assign player2_pause = r_pause | ~r_link_up;
        end else begin : g_pause_hold
            assign player2_pause = r_pause;
        end
    endgenerate

    assign player2_score = r_score;
    assign frame_valid   = r_frame_valid;
    assign frame_err     = r_frame_err;
    assign link_up       = r_link_up;

endmodule
`default_nettype wire

// File: doc/ctl_link_rx.md
Name: ctl_link_rx

Overview:
- Receiving end of the inter-board player link.
- The peer board transmits its local pause level and score as a serial UART-style frame on one wire.
- This block synchronises and deserialises that line, checks parity and stop bit, and holds the last valid fields.
- Its player2_pause output feeds the pause logic; it also reports link health so the game can react to a missing or broken peer.

Parameters:
- CLKS_PER_BIT, 650, clk cycles per serial bit (65 MHz / 100 kbaud); must be ≥ 8.
- TIMEOUT_CYCLES, 6_500_000, cycles without a valid frame before the link is declared down (100 ms).
- PAUSE_ON_LOSS, 0, when 1, player2_pause is forced to 1 while link_up = 0.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_raw  in  1  serial line from peer board; asynchronous; idles high
- player2_pause  out  1  peer pause level from last valid frame (subject to PAUSE_ON_LOSS)
- player2_score  out  7  peer score from last valid frame, 0..127
- frame_valid  out  1  one-cycle pulse when a good frame updates the outputs
- frame_err  out  1  one-cycle pulse on parity or stop-bit error
- link_up  out  1  1 while a valid frame has arrived within the last TIMEOUT_CYCLES

Behaviour:
- Reset (asynchronous, active-high) drives every output and register to 0: player2_pause=0, player2_score=0, frame_valid=0, frame_err=0, link_up=0, FSM in IDLE. Synchroniser flops reset to 1 (idle line level).
- Synchroniser: rx_raw passes through 2 flops to give rx_s. All logic uses rx_s only.
- Frame format: start bit (0), then 8 data bits LSB first, then an even parity bit over the 8 data bits, then a stop bit (1).
  - Data bit 0 = pause.
  - Data bits 7:1 = score.
- FSM states and transitions:
  - IDLE: a falling edge of rx_s (previous 1, current 0) loads the bit counter with CLKS_PER_BIT/2 − 1 and moves to START.
  - START: when the counter expires, sample rx_s. If 1, it was a false start; return to IDLE with no pulse. If 0, reload CLKS_PER_BIT − 1, clear the bit index, go to DATA.
  - DATA: on each counter expiry, shift rx_s into the shift register MSB and shift right. After 8 samples go to PARITY.
  - PARITY: sample the parity bit, then go to STOP.
  - STOP: sample at mid-bit and evaluate the frame:
    - Stop = 1 and parity OK: next cycle register pause/score, pulse frame_valid, go to IDLE.
    - Stop = 0: pulse frame_err, outputs hold, go to BREAK.
    - Stop = 1 but parity wrong: pulse frame_err, outputs hold, go to IDLE.
  - BREAK: wait until rx_s = 1, then go to IDLE. This prevents re-triggering on a held-low line.
- Latency: from the rx_raw falling edge to the frame_valid pulse is 2 + CLKS_PER_BIT/2 + 10·CLKS_PER_BIT + 2 cycles, with ±1 cycle tolerance.
- player2_score and player2_pause change only in the same cycle frame_valid is asserted.
- Timeout counter:
  - Cleared in the cycle frame_valid pulses; increments otherwise and saturates at TIMEOUT_CYCLES.
  - link_up is registered: it goes to 1 one cycle after frame_valid and to 0 when the counter reaches TIMEOUT_CYCLES.
  - Erroneous frames do not reset the counter.
- PAUSE_ON_LOSS = 1: player2_pause = stored_pause OR NOT link_up. After reset this makes player2_pause = 1 until the first good frame, and the pause output does not itself reset to 0.
- PAUSE_ON_LOSS = 0: player2_pause = stored_pause only. Stored fields are kept when the link drops.
- Simultaneous events:
  - A timeout expiring in the same cycle as frame_valid: frame_valid wins, link_up stays 1.
  - A falling edge arriving during BREAK is ignored.
- Reset mid-frame aborts the frame immediately. No pulse is produced, and the next falling edge after reset release starts a fresh frame.

Test Plan:
- Use CLKS_PER_BIT=16, TIMEOUT_CYCLES=2000, PAUSE_ON_LOSS=0 unless stated otherwise.
- Good frame, byte 0x54 (score 42, pause 0), parity 1 → one frame_valid pulse; player2_score=42, player2_pause=0, link_up=1; latency 172±1 cycles from the rx falling edge.
- Good frame, byte 0x01, parity 1 → player2_pause=1, score=0. Then send byte 0x00, parity 0 → player2_pause returns to 0.
- Byte 0x54 with parity 0 → frame_err pulse, no frame_valid, outputs keep their prior values.
- Stop bit forced 0 and line held low for 100 cycles, then released → exactly one frame_err; no new frame starts until the line returns high; the next good frame is accepted.
- Glitch low lasting 4 cycles on an idle line → no pulses, FSM back in IDLE.
- After a valid frame, line idles 2000 cycles → link_up falls to 0.
  - With PAUSE_ON_LOSS=1, player2_pause=1 from reset until the first good frame and again after the timeout.
- Assert rst mid-DATA → all outputs 0 immediately; a frame sent after release decodes correctly.
